// File: rtl/serial_pkg.sv
// Shared types and reset constants for the serial transmit path.
// The PARITY state only exists when SERIAL_TX_PARITY_EN is defined.
package serial_pkg;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_e;
`endif

    localparam logic DOUT_RST = 1'b0;
    localparam logic OVLD_RST = 1'b0;

endpackage

// File: rtl/bit_counter.sv
// Modulo-WIDTH up-counter with clear, enable and terminal-count output.
// Clear takes priority over enable.
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter with ready/valid input and registered serial output.
// Optional even-parity bit per frame when SERIAL_TX_PARITY_EN is defined.
module serial_tx_piso
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    output logic             inReady,
    output logic             dataOut,
    output logic             outValid,
    output logic             frameStart,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dout_q, dout_d;
    logic             ovld_q, ovld_d;
    logic             fs_q, fs_d;
    logic             up_q;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic             last_cycle, accept;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

`ifdef SERIAL_TX_PARITY_EN
    assign last_cycle = (state_q == PARITY);
`else
    assign last_cycle = (state_q == SHIFT) && cnt_tc;
`endif

    // up_q keeps inReady low through reset and for the edge that releases it
    assign inReady    = up_q && ((state_q == IDLE) || last_cycle);
    assign accept     = inValid && inReady;
    assign dataOut    = dout_q;
    assign outValid   = ovld_q;
    assign frameStart = fs_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dout_d  = DOUT_RST;
        ovld_d  = OVLD_RST;
        fs_d    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // First bit goes straight to the output register; the shifter holds the rest
            state_d = SHIFT;
            cnt_clr = 1'b1;
            ovld_d  = 1'b1;
            fs_d    = 1'b1;
            dout_d  = MSB_FIRST ? inData[WIDTH-1] : inData[0];
            shreg_d = MSB_FIRST ? {inData[WIDTH-2:0], 1'b0} : {1'b0, inData[WIDTH-1:1]};
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^inData;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (!cnt_tc) begin
                        cnt_en  = 1'b1;
                        ovld_d  = 1'b1;
                        dout_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_q[WIDTH-1:1]};
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        ovld_d  = 1'b1;
                        dout_d  = par_q;
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dout_q  <= DOUT_RST;
            ovld_q  <= OVLD_RST;
            fs_q    <= 1'b0;
            up_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            ovld_q  <= ovld_d;
            fs_q    <= fs_d;
            up_q    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx_piso.sv
// Directed bench for serial_tx_piso: MSB-first and LSB-first instances sharing clk/rst_n.
// Frame length follows SERIAL_TX_PARITY_EN.
module tb_serial_tx_piso;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_inData = '0, b_inData = '0;
    logic       a_inValid = 1'b0, b_inValid = 1'b0;
    logic       a_inReady, a_dataOut, a_outValid, a_frameStart, a_busy;
    logic       b_inReady, b_dataOut, b_outValid, b_frameStart, b_busy;
    logic       sel_v = 1'b0;
    logic       s_rdy, s_dout, s_ovld, s_fs, s_busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .inData(a_inData), .inValid(a_inValid),
        .inReady(a_inReady), .dataOut(a_dataOut), .outValid(a_outValid),
        .frameStart(a_frameStart), .busy(a_busy)
    );

    serial_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .inData(b_inData), .inValid(b_inValid),
        .inReady(b_inReady), .dataOut(b_dataOut), .outValid(b_outValid),
        .frameStart(b_frameStart), .busy(b_busy)
    );

    assign s_rdy  = sel_v ? b_inReady    : a_inReady;
    assign s_dout = sel_v ? b_dataOut    : a_dataOut;
    assign s_ovld = sel_v ? b_outValid   : a_outValid;
    assign s_fs   = sel_v ? b_frameStart : a_frameStart;
    assign s_busy = sel_v ? b_busy       : a_busy;

    typedef struct {
        logic       sel;   // 0: MSB-first instance, 1: LSB-first instance
        logic [7:0] word;
        logic [7:0] seq;   // expected serial bits, seq[7] sent first
        logic       par;   // expected even-parity bit
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic vld, input logic [7:0] d);
        if (sel) begin
            b_inValid = vld;
            b_inData  = d;
        end else begin
            a_inValid = vld;
            a_inData  = d;
        end
    endtask

    task automatic run_frame(input logic sel, input logic [7:0] word,
                             input logic [7:0] seq, input logic par);
        logic exp_bit;
        sel_v = sel;
        #0;
        check("ready_before", s_rdy, 1'b1);
        drive(sel, 1'b1, word);
        tick();
        drive(sel, 1'b0, 8'h5A);
        for (int i = 0; i < FL; i++) begin
            exp_bit = (i < 8) ? seq[7-i] : par;
            check($sformatf("dout[%0d]", i), s_dout, exp_bit);
            check($sformatf("ovld[%0d]", i), s_ovld, 1'b1);
            check($sformatf("fs[%0d]", i), s_fs, (i == 0));
            check($sformatf("rdy[%0d]", i), s_rdy, (i == FL - 1));
            check($sformatf("busy[%0d]", i), s_busy, 1'b1);
            tick();
        end
        check("ovld_after", s_ovld, 1'b0);
        check("busy_after", s_busy, 1'b0);
        check("dout_after", s_dout, 1'b0);
        check("fs_after", s_fs, 1'b0);
    endtask

    initial begin
        logic [15:0] b2b_seq;
        logic        exp_bit;

        vecs[0] = '{sel: 1'b0, word: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
        vecs[1] = '{sel: 1'b0, word: 8'h3C, seq: 8'b0011_1100, par: 1'b0};
        vecs[2] = '{sel: 1'b0, word: 8'h07, seq: 8'b0000_0111, par: 1'b1};
        vecs[3] = '{sel: 1'b0, word: 8'h00, seq: 8'b0000_0000, par: 1'b0};
        vecs[4] = '{sel: 1'b1, word: 8'h01, seq: 8'b1000_0000, par: 1'b1};
        vecs[5] = '{sel: 1'b1, word: 8'hB2, seq: 8'b0100_1101, par: 1'b0};

        // Reset state
        #12;
        check("rst_rdy", a_inReady, 1'b0);
        check("rst_dout", a_dataOut, 1'b0);
        check("rst_ovld", a_outValid, 1'b0);
        check("rst_fs", a_frameStart, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_not_early", a_inReady, 1'b0);
        tick();
        check("rdy_after_rst", a_inReady, 1'b1);

        // Idle: 20 cycles with no valid
        for (int i = 0; i < 20; i++) begin
            check($sformatf("idle_rdy[%0d]", i), a_inReady, 1'b1);
            check($sformatf("idle_ovld[%0d]", i), a_outValid, 1'b0);
            tick();
        end

        for (int v = 0; v < 6; v++)
            run_frame(vecs[v].sel, vecs[v].word, vecs[v].seq, vecs[v].par);

        // Back-to-back A5 then 3C; 3C is presented early and must wait for ready
        sel_v = 1'b0;
        b2b_seq = 16'hA53C;
        a_inValid = 1'b1;
        a_inData  = 8'hA5;
        tick();
        a_inData  = 8'h3C;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i < FL) exp_bit = (i < 8) ? b2b_seq[15-i] : 1'b0;
            else        exp_bit = (i - FL < 8) ? b2b_seq[7-(i-FL)] : 1'b0;
            check($sformatf("b2b_dout[%0d]", i), a_dataOut, exp_bit);
            check($sformatf("b2b_ovld[%0d]", i), a_outValid, 1'b1);
            check($sformatf("b2b_fs[%0d]", i), a_frameStart, (i == 0) || (i == FL));
            check($sformatf("b2b_rdy[%0d]", i), a_inReady, (i == FL - 1) || (i == 2 * FL - 1));
            tick();
            if (i == FL) a_inValid = 1'b0;
        end
        check("b2b_end_ovld", a_outValid, 1'b0);

        // Reset mid-frame after the 3rd bit of 0xFF
        a_inValid = 1'b1;
        a_inData  = 8'hFF;
        tick();
        a_inValid = 1'b0;
        tick();
        tick();
        check("ff_bit3", a_dataOut, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_dout", a_dataOut, 1'b0);
        check("abort_ovld", a_outValid, 1'b0);
        check("abort_busy", a_busy, 1'b0);
        check("abort_rdy", a_inReady, 1'b0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post_rst_ovld[%0d]", i), a_outValid, 1'b0);
            check($sformatf("post_rst_dout[%0d]", i), a_dataOut, 1'b0);
            check($sformatf("post_rst_rdy[%0d]", i), a_inReady, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_tx_piso.md
SERIAL_TX_PISO -- requirements
Module: serial_tx_piso

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of data bits per word (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; when 1, bit WIDTH-1 is sent first, otherwise bit 0 is sent first.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port inData, input, WIDTH bits, the parallel word to serialize.
REQ-006 SHALL have port inValid, input, 1 bit, meaning inData holds a word.
REQ-007 SHALL have port inReady, output, 1 bit, meaning the block accepts a word this cycle.
REQ-008 SHALL have port dataOut, output, 1 bit, the registered serial bit stream that drives the dataIn port of the downstream shift register.
REQ-009 SHALL have port outValid, output, 1 bit, high in every cycle in which dataOut carries a frame bit.
REQ-010 SHALL have port frameStart, output, 1 bit, high only in the cycle that carries the first bit of a frame.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT, and PARITY (PARITY exists only per REQ-025).
REQ-013 SHALL accept a word on a rising edge where inValid and inReady are both high: load it into the shift register, clear the bit counter, and enter SHIFT.
REQ-014 SHALL drive inReady high in IDLE, and in the final frame cycle (last data bit, or the parity bit when parity is enabled); it SHALL be low otherwise.
REQ-015 SHALL place the first bit on dataOut in the cycle after the accepting edge, with outValid=1 and frameStart=1 (latency 1).
REQ-016 SHALL output one bit per cycle in SHIFT, advancing the counter 0..WIDTH-1 with no gaps.
REQ-017 SHALL, when counter=WIDTH-1, either accept a pending word (back-to-back) and re-enter SHIFT with counter=0, or else go to PARITY or IDLE.
REQ-018 SHALL make back-to-back frames contiguous: outValid stays high, and frameStart pulses on the first bit of each frame.
REQ-019 SHALL ignore changes to inData and inValid while not ready; the captured word is immutable until the frame ends.
REQ-020 SHALL, in IDLE, drive dataOut=0, outValid=0, frameStart=0 and busy=0.
REQ-021 SHALL size the counter at $clog2(WIDTH) bits and never let it wrap inside a frame.

Reset
REQ-022 SHALL, on rst_n low, immediately force state=IDLE, shift register=0, counter=0, dataOut=0, outValid=0, frameStart=0, busy=0 and inReady=0.
REQ-023 SHALL abort any frame in progress when reset is asserted mid-frame, with no partial bits emitted after the reset.
REQ-024 SHALL raise inReady in the first cycle after rst_n deasserts, not earlier.

Configuration
REQ-025 SHALL, with macro SERIAL_TX_PARITY_EN defined, append one even-parity bit (XOR of the WIDTH data bits) in a PARITY state after the last data bit, with outValid=1, making frames WIDTH+1 cycles.
REQ-026 SHALL, without SERIAL_TX_PARITY_EN, omit the PARITY state entirely, making frames WIDTH cycles.

Structure
REQ-027 SHALL take the state enum typedef (IDLE/SHIFT/PARITY) and the reset constants for dataOut/outValid from shared package serial_pkg.
REQ-028 SHALL instantiate one sub-module, bit_counter (a modulo-WIDTH up-counter with a clear input, an enable input and a terminal-count output), and keep the FSM and shifter in serial_tx_piso.

Verification
REQ-029 SHALL check: WIDTH=8, MSB_FIRST=1, word 0xA5 -> dataOut 1,0,1,0,0,1,0,1 on 8 consecutive cycles, frameStart on cycle 1 only, then outValid=0.
REQ-030 SHALL check: 0xA5 then 0x3C presented back-to-back -> 16 contiguous outValid cycles, frameStart on cycles 1 and 9, inReady high on cycles 8 and 16.
REQ-031 SHALL check: with SERIAL_TX_PARITY_EN, 0xA5 -> parity bit 0 on cycle 9; 0x07 -> parity bit 1; frame length 9.
REQ-032 SHALL check: rst_n pulsed low after the 3rd bit of 0xFF -> dataOut=0, outValid=0 and busy=0 immediately; no further bits emitted.
REQ-033 SHALL check: MSB_FIRST=0, word 0x01 -> first bit 1, then 7 zeros.
REQ-034 SHALL check: inValid held low for 20 cycles -> inReady=1 and outValid=0 throughout.
